// File: rtl/perip_pkg.sv
// perip_pkg: address map, mask encodings, status bit indices and state types for perip_bridge
package perip_pkg;
    localparam logic [31:0] DRAM_BASE  = 32'h8010_0000;
    localparam logic [31:0] DRAM_LAST  = 32'h8013_FFFF;
    localparam logic [31:0] SW_ADDR    = 32'h8020_0000;
    localparam logic [31:0] LED_ADDR   = 32'h8020_0040;
    localparam logic [31:0] CNT_ADDR   = 32'h8020_0050;
    localparam logic [31:0] CTRL_ADDR  = 32'h8020_0054;
    localparam logic [31:0] UDATA_ADDR = 32'h8020_0060;
    localparam logic [31:0] USTAT_ADDR = 32'h8020_0064;

    localparam logic [1:0] MASK_BYTE = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_WORD = 2'b10;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [1:0] {SEL_NONE, SEL_DRAM, SEL_MMIO} sel_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    function automatic logic is_dram(input logic [31:0] addr);
        return addr >= DRAM_BASE && addr <= DRAM_LAST;
    endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 transmitter with a CLK_HZ/BAUD bit timer
module uart_tx_fifo
    import perip_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200,
    parameter int DEPTH  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] data_i,
    output logic       full_o,
    output logic       empty_o,
    output logic       busy_o,
    output logic       tx_o,
    output logic       drop_o
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int BW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    tx_state_e     state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          tx_q, tick, pop, push_ok;

    assign tick    = baud_q == BW'(DIV - 1);
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign busy_o  = state_q != TX_IDLE;
    assign tx_o    = tx_q;
    // A pop in the same cycle frees a slot, so a push to a full FIFO still lands
    assign pop     = !empty_o && (state_q == TX_IDLE || (state_q == TX_STOP && tick));
    assign push_ok = push_i && (!full_o || pop);
    assign drop_o  = push_i && !push_ok;

    always_ff @(posedge clk)
        if (push_ok) mem_q[wptr_q] <= data_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            baud_q <= (state_q == TX_IDLE || tick) ? '0 : baud_q + 1'b1;
            case (state_q)
                TX_IDLE:
                    if (pop) begin
                        state_q <= TX_START;
                        sh_q    <= mem_q[rptr_q];
                        tx_q    <= 1'b0;
                    end
                TX_START:
                    if (tick) begin
                        state_q <= TX_DATA;
                        bit_q   <= '0;
                        tx_q    <= sh_q[0];
                    end
                TX_DATA:
                    if (tick) begin
                        sh_q    <= sh_q >> 1;
                        bit_q   <= bit_q + 1'b1;
                        state_q <= bit_q == 3'd7 ? TX_STOP : TX_DATA;
                        tx_q    <= bit_q == 3'd7 ? 1'b1 : sh_q[1];
                    end
                TX_STOP:
                    if (tick) begin
                        state_q <= pop ? TX_START : TX_IDLE;
                        tx_q    <= !pop;
                        if (pop) sh_q <= mem_q[rptr_q];
                    end
            endcase
        end
    end
endmodule

// File: rtl/perip_bridge.sv
// perip_bridge: decodes core data-bus accesses into DRAM and MMIO (SW, LED, counter, UART)
// and returns read data one cycle later through a registered select.
module perip_bridge
    import perip_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int TXQ_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] perip_addr,
    input  logic        perip_wen,
    input  logic [1:0]  perip_mask,
    input  logic [31:0] perip_wdata,
    output logic [31:0] perip_rdata,
    output logic [31:0] dram_addr,
    output logic        dram_wen,
    output logic [1:0]  dram_mask,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        uart_tx
);
    logic [29:0] w;
    logic        dram_hit, sw_hit, led_hit, cnt_hit, ctrl_hit, udata_hit, ustat_hit;
    logic        full, empty, busy, drop;
    logic [31:0] stat, mmio_d, rmmio_q, cnt_q;
    logic [15:0] led_q;
    logic        run_q, ovf_q;
    sel_e        sel_d, rsel_q;

    assign w         = perip_addr[31:2];
    assign dram_hit  = is_dram(perip_addr);
    assign sw_hit    = w == SW_ADDR[31:2];
    assign led_hit   = w == LED_ADDR[31:2];
    assign cnt_hit   = w == CNT_ADDR[31:2];
    assign ctrl_hit  = w == CTRL_ADDR[31:2];
    assign udata_hit = w == UDATA_ADDR[31:2];
    assign ustat_hit = w == USTAT_ADDR[31:2];

    assign dram_addr  = perip_addr;
    assign dram_wen   = perip_wen && dram_hit;
    assign dram_mask  = perip_mask;
    assign dram_wdata = perip_wdata;
    assign led        = led_q;

    always_comb begin
        stat = '0;
        stat[STAT_EMPTY] = empty;
        stat[STAT_FULL]  = full;
        stat[STAT_BUSY]  = busy;
        stat[STAT_OVF]   = ovf_q;
    end

    assign mmio_d = sw_hit    ? {16'b0, sw} :
                    led_hit   ? {16'b0, led_q} :
                    cnt_hit   ? cnt_q :
                    ctrl_hit  ? {31'b0, run_q} :
                    ustat_hit ? stat : '0;
    assign sel_d  = dram_hit ? SEL_DRAM :
                    (sw_hit || led_hit || cnt_hit || ctrl_hit || udata_hit || ustat_hit) ? SEL_MMIO : SEL_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            ovf_q   <= 1'b0;
            rsel_q  <= SEL_NONE;
            rmmio_q <= '0;
        end else begin
            if (perip_wen && led_hit) led_q <= perip_wdata[15:0];
            if (perip_wen && ctrl_hit) run_q <= perip_wdata[0];
            cnt_q   <= (perip_wen && cnt_hit) ? perip_wdata : cnt_q + {31'b0, run_q};
            // A drop in the same cycle as a status read keeps ovf set
            ovf_q   <= drop || (ovf_q && !(!perip_wen && ustat_hit));
            rsel_q  <= sel_d;
            rmmio_q <= mmio_d;
        end
    end

    assign perip_rdata = rsel_q == SEL_DRAM ? dram_rdata :
                         rsel_q == SEL_MMIO ? rmmio_q : '0;

    uart_tx_fifo #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD),
        .DEPTH (TXQ_DEPTH)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .push_i (perip_wen && udata_hit),
        .data_i (perip_wdata[7:0]),
        .full_o (full),
        .empty_o(empty),
        .busy_o (busy),
        .tx_o   (uart_tx),
        .drop_o (drop)
    );
endmodule

// File: tb/tb_perip_bridge.sv
// tb_perip_bridge: directed checks of perip_bridge with a divider of 4 (CLK_HZ=400, BAUD=100)
module tb_perip_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] perip_addr, perip_wdata, perip_rdata, dram_addr, dram_wdata, dram_rdata;
    logic        perip_wen, dram_wen, uart_tx;
    logic [1:0]  perip_mask, dram_mask;
    logic [15:0] sw, led;
    logic [31:0] dmem [16];
    logic [7:0]  rx_q [$];
    logic [7:0]  rx_b;
    int          checks = 0;
    int          failures = 0;

    perip_bridge #(.CLK_HZ(400), .BAUD(100), .TXQ_DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .perip_addr (perip_addr),
        .perip_wen  (perip_wen),
        .perip_mask (perip_mask),
        .perip_wdata(perip_wdata),
        .perip_rdata(perip_rdata),
        .dram_addr  (dram_addr),
        .dram_wen   (dram_wen),
        .dram_mask  (dram_mask),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .led        (led),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dram_wen) dmem[dram_addr[5:2]] <= dram_wdata;
        dram_rdata <= dmem[dram_addr[5:2]];
    end

    initial begin
        forever begin
            @(negedge uart_tx);
            repeat (2) @(posedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (4) @(posedge clk);
                #1 rx_b[k] = uart_tx;
            end
            repeat (4) @(posedge clk);
            rx_q.push_back(rx_b);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        perip_addr  = a;
        perip_wdata = d;
        perip_wen   = 1'b1;
        tick();
        perip_wen   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        perip_addr = a;
        perip_wen  = 1'b0;
        tick();
        d = perip_rdata;
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        int          n;
        for (int i = 0; i < 16; i++) dmem[i] = '0;
        perip_addr  = '0;
        perip_wen   = 1'b0;
        perip_mask  = 2'b10;
        perip_wdata = '0;
        sw          = 16'h1234;
        repeat (3) tick();
        check("rst_rdata", perip_rdata, 32'h0);
        check("rst_led", {16'b0, led}, 32'h0);
        check("rst_tx", {31'b0, uart_tx}, 32'h1);
        rst = 1'b0;
        rd(32'h8020_0064, r); check("rst_stat", r, 32'h1);
        rd(32'h8020_0000, r); check("sw_read", r, 32'h1234);

        wr(32'h8020_0040, 32'h0000_A5A5);
        check("led_out", {16'b0, led}, 32'hA5A5);
        rd(32'h8020_0040, r); check("led_read", r, 32'h0000_A5A5);
        perip_mask = 2'b00;
        wr(32'h8020_0040, 32'hFFFF_1234);
        perip_mask = 2'b10;
        check("led_byte_wr", {16'b0, led}, 32'h1234);
        rd(32'h8020_0044, r); check("unmapped_read", r, 32'h0);

        wr(32'h8020_0050, 32'h10);
        wr(32'h8020_0054, 32'h1);
        repeat (5) tick();
        rd(32'h8020_0050, r); check("cnt_run", r, 32'h15);
        rd(32'h8020_0054, r); check("cnt_ctrl", r, 32'h1);
        wr(32'h8020_0050, 32'hFFFF_FFFE);
        rd(32'h8020_0050, r); check("cnt_load", r, 32'hFFFF_FFFE);
        rd(32'h8020_0050, r); check("cnt_max", r, 32'hFFFF_FFFF);
        rd(32'h8020_0050, r); check("cnt_wrap", r, 32'h0);
        wr(32'h8020_0054, 32'h0);

        perip_addr  = 32'h8010_0004;
        perip_wdata = 32'hDEAD_BEEF;
        perip_wen   = 1'b1;
        #1;
        check("dram_wen_hit", {31'b0, dram_wen}, 32'h1);
        check("dram_addr", dram_addr, 32'h8010_0004);
        check("dram_wdata", dram_wdata, 32'hDEAD_BEEF);
        tick();
        perip_wen = 1'b0;
        #1;
        check("dram_wen_drop", {31'b0, dram_wen}, 32'h0);
        rd(32'h8010_0004, r); check("dram_read", r, 32'hDEAD_BEEF);
        perip_wen  = 1'b1;
        perip_addr = 32'h8013_FFFC; #1; check("dram_top", {31'b0, dram_wen}, 32'h1);
        perip_addr = 32'h8014_0000; #1; check("dram_above", {31'b0, dram_wen}, 32'h0);
        perip_addr = 32'h800F_FFFC; #1; check("dram_below", {31'b0, dram_wen}, 32'h0);
        perip_addr = 32'h9000_0000; #1; check("dram_far", {31'b0, dram_wen}, 32'h0);
        tick();
        perip_wen = 1'b0;
        rd(32'h9000_0000, r); check("far_read", r, 32'h0);

        b = 8'h55;
        wr(32'h8020_0060, {24'b0, b});
        perip_addr = 32'h8020_0064;
        for (int i = 0; i < 42; i++) begin
            tick();
            check("tx_line", {31'b0, uart_tx}, i < 4 ? 32'h0 : i < 36 ? {31'b0, b[(i - 4) / 4]} : 32'h1);
            check("tx_stat", perip_rdata, i == 0 ? 32'h0 : i <= 40 ? 32'h5 : 32'h1);
        end
        check("rx_count1", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check("rx_byte55", {24'b0, rx_q[0]}, 32'h55);
        rx_q.delete();

        for (int k = 0; k < 10; k++) wr(32'h8020_0060, 32'hA0 + k);
        rd(32'h8020_0064, r); check("ovf_stat", r, 32'hE);
        rd(32'h8020_0064, r); check("ovf_clear", r, 32'h6);
        n = 0;
        while (rx_q.size() < 9 && n < 1000) begin
            tick();
            n++;
        end
        check("drain_timeout", {31'b0, n >= 1000}, 32'h0);
        repeat (60) tick();
        check("rx_count9", rx_q.size(), 32'd9);
        for (int k = 0; k < 9; k++)
            if (k < rx_q.size()) check("rx_byte", {24'b0, rx_q[k]}, 32'hA0 + k);
        rd(32'h8020_0064, r); check("drained_stat", r, 32'h1);

        wr(32'h8020_0040, 32'h00FF);
        wr(32'h8020_0060, 32'h3C);
        repeat (8) tick();
        rd(32'h8020_0064, r); check("mid_stat", r, 32'h5);
        check("tx_before_rst", {31'b0, uart_tx}, 32'h0);
        rst = 1'b1;
        tick();
        check("rst_mid_tx", {31'b0, uart_tx}, 32'h1);
        check("rst_mid_led", {16'b0, led}, 32'h0);
        check("rst_mid_rdata", perip_rdata, 32'h0);
        rst = 1'b0;
        rd(32'h8020_0064, r); check("rst_mid_stat", r, 32'h1);
        rd(32'h8020_0050, r); check("rst_mid_cnt", r, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
